// File: rtl/mod_sub_serial.sv
// Limb-serial modular subtractor: result = (a - b) mod P, one W-bit limb per clock.
// Operands shift out of the bottom of r_a/r_b while the difference shifts in at the top of r_d.
module mod_sub_serial #(
  parameter int          N = 256,
  parameter int          W = 32,
  parameter logic [N-1:0] P = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         wrapped
);

  // state  | meaning
  // S_IDLE | waiting for operands
  // S_SUB  | limb-serial a - b with borrow chain
  // S_FIX  | difference borrowed: limb-serial add of P with carry chain
  // S_DONE | result held until out_ready

  localparam int L    = N / W;
  localparam int IDXW = (L > 1) ? $clog2(L) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(L - 1);

  if (N % W != 0) begin : g_bad_limb_width
    $error("mod_sub_serial: N must be a multiple of W");
  end

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_FIX, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_d;
  logic [N-1:0]    r_result;
  logic            r_wrapped;
  logic [IDXW-1:0] r_idx;
  logic            r_bc;

  logic            w_last;
  logic [W:0]      w_diff;
  logic [W:0]      w_sum;
  logic [N-1:0]    w_d_sub;
  logic [N-1:0]    w_d_fix;

  assign w_last  = (r_idx == LAST);
  assign w_diff  = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_bc};
  // In FIX, r_a has been reloaded with P so the same shift path feeds the modulus limbs.
  assign w_sum   = {1'b0, r_d[W-1:0]} + {1'b0, r_a[W-1:0]} + {{W{1'b0}}, r_bc};
  assign w_d_sub = (r_d >> W) | (N'(w_diff[W-1:0]) << (N - W));
  assign w_d_fix = (r_d >> W) | (N'(w_sum[W-1:0]) << (N - W));

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign wrapped   = r_wrapped;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_SUB;
      S_SUB:  if (w_last) w_state_nxt = w_diff[W] ? S_FIX : S_DONE;
      S_FIX:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_result  <= '0;
      r_wrapped <= 1'b0;
      r_idx     <= '0;
      r_bc      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= '0;
            r_bc  <= 1'b0;
          end
        end
        S_SUB: begin
          r_a   <= r_a >> W;
          r_b   <= r_b >> W;
          r_d   <= w_d_sub;
          r_bc  <= w_diff[W];
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_idx <= '0;
            if (w_diff[W]) begin
              r_a  <= P;
              r_bc <= 1'b0;
            end else begin
              r_result  <= w_d_sub;
              r_wrapped <= 1'b0;
            end
          end
        end
        S_FIX: begin
          r_a   <= r_a >> W;
          r_d   <= w_d_fix;
          r_bc  <= w_sum[W];
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_idx     <= '0;
            r_result  <= w_d_fix;
            r_wrapped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sub_serial.sv
// Self-checking bench for mod_sub_serial: directed vector table, backpressure and
// mid-operation reset sequences, then random operands against a wide-arithmetic model.
module tb_mod_sub_serial;

  localparam int N = 256;
  localparam int W = 32;
  localparam int L = N / W;
  localparam logic [N-1:0] P = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         wrapped;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         wr;
    int           cyc;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mod_sub_serial #(.N(N), .W(W), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .wrapped   (wrapped)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [N-1:0] rnd_lt_p();
    logic [N-1:0] v;
    v = rnd_word();
    v[N-1] = 1'b0;
    if (v >= P) v = v - P;
    return v;
  endfunction

  // Reference: plain wide arithmetic on the operands as integers.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                       output logic [N-1:0] res, output logic wr, output int cyc);
    logic [N:0] t;
    if (ma >= mb) begin
      t   = {1'b0, ma} - {1'b0, mb};
      wr  = 1'b0;
      cyc = L;
    end else begin
      t   = {1'b0, ma} + {1'b0, P} - {1'b0, mb};
      wr  = 1'b1;
      cyc = 2 * L;
    end
    res = t[N-1:0];
  endtask

  task automatic start_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_in_ready"}, N'(in_ready), N'(1'b1));
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = rnd_word();
    b        = rnd_word();
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           input logic [N-1:0] er, input logic ew, input int ec, input int hold);
    int cyc;
    start_op(name, ta, tb_v);
    wait_valid(cyc);
    chk({name, "_latency"}, N'(cyc), N'(ec));
    chk({name, "_result"}, result, er);
    chk({name, "_wrapped"}, N'(wrapped), N'(ew));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = rnd_lt_p();
      b        = rnd_lt_p();
      @(posedge clk);
      #1;
      chk({name, "_hold_result"}, result, er);
      chk({name, "_hold_wrapped"}, N'(wrapped), N'(ew));
      chk({name, "_hold_in_ready"}, N'(in_ready), N'(1'b0));
      chk({name, "_hold_out_valid"}, N'(out_valid), N'(1'b1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_ready_after"}, N'(in_ready), N'(1'b1));
    chk({name, "_valid_after"}, N'(out_valid), N'(1'b0));
  endtask

  initial begin
    logic [N-1:0] ra, rb, er;
    logic         ew;
    int           ec;
    int           mode;

    vecs[0] = '{256'd5, 256'd3, 256'd2, 1'b0, 8};
    vecs[1] = '{256'd3, 256'd5,
                256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEB, 1'b1, 16};
    vecs[2] = '{256'h1_00000000, 256'd1, 256'hFFFFFFFF, 1'b0, 8};
    vecs[3] = '{256'd0,
                256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEC,
                256'd1, 1'b1, 16};
    vecs[4] = '{256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEC,
                256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEC,
                256'd0, 1'b0, 8};
    vecs[5] = '{256'd10, 256'd7, 256'd3, 1'b0, 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", N'(in_ready), N'(1'b0));
    chk("rst_out_valid", N'(out_valid), N'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_wrapped", N'(wrapped), N'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", N'(in_ready), N'(1'b1));

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].wr, vecs[i].cyc, 0);

    // Backpressure: result held for 5 cycles while stray in_valid pulses are ignored.
    run_check("backpressure", 256'd100, 256'd1, 256'd99, 1'b0, 8, 5);
    run_check("after_bp", 256'd7, 256'd9,
              256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEB, 1'b1, 16, 2);

    // Reset pulse while the borrow chain is at limb 3.
    start_op("midrst", 256'd3, 256'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", N'(in_ready), N'(1'b0));
    chk("midrst_out_valid", N'(out_valid), N'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", N'(in_ready), N'(1'b1));
    chk("midrst_valid_after", N'(out_valid), N'(1'b0));
    run_check("after_rst", 256'd10, 256'd7, 256'd3, 1'b0, 8, 0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      ra   = rnd_lt_p();
      rb   = rnd_lt_p();
      if (mode == 1) rb = ra;
      if (mode == 2) begin
        ra = N'($urandom_range(0, 1000));
        rb = N'($urandom_range(0, 1000));
      end
      if (mode == 3 && ra < P - 1) rb = ra + 1;
      model(ra, rb, er, ew, ec);
      run_check($sformatf("rnd%0d", i), ra, rb, er, ew, ec, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
